// File: rtl/rs_station.sv
// Reservation station for one functional-unit class: buffers renamed instructions, wakes sources
// from CDB broadcasts, issues one ready entry per cycle. Define RS_AGE_SELECT_EN for oldest-first.
module rs_station #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic [PAYLOAD_W-1:0]       alloc_payload_i,
  input  logic [TAG_W-1:0]           alloc_prs1_i,
  input  logic [TAG_W-1:0]           alloc_prs2_i,
  input  logic [TAG_W-1:0]           alloc_prd_i,
  input  logic                       alloc_prs1_rdy_i,
  input  logic                       alloc_prs2_rdy_i,
  input  logic                       cdb_en_i,
  input  logic [TAG_W-1:0]           cdb_tag_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [PAYLOAD_W-1:0]       issue_payload_o,
  output logic [TAG_W-1:0]           issue_prs1_o,
  output logic [TAG_W-1:0]           issue_prs2_o,
  output logic [TAG_W-1:0]           issue_prd_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  logic [DEPTH-1:0]     valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [TAG_W-1:0]     prs1_q [DEPTH];
  logic [TAG_W-1:0]     prs1_d [DEPTH];
  logic [TAG_W-1:0]     prs2_q [DEPTH];
  logic [TAG_W-1:0]     prs2_d [DEPTH];
  logic [TAG_W-1:0]     prd_q [DEPTH];
  logic [TAG_W-1:0]     prd_d [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [DEPTH];
  logic [CW-1:0]        count_q, count_d;

  logic [DEPTH-1:0] eligible;
  logic [IW-1:0]    sel_idx, free_idx;
  logic             sel_found;
  logic             alloc_fire, issue_fire;

  assign eligible = valid_q & rdy1_q & rdy2_q;

`ifdef RS_AGE_SELECT_EN
  // older_q[i] has bit j set when entry j was allocated before entry i.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && eligible[i] && ((older_q[i] & eligible) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

  assign alloc_ready_o   = (count_q != CW'(DEPTH)) && !reset_i && !flush_i;
  assign alloc_fire      = alloc_valid_i && alloc_ready_o;
  assign issue_valid_o   = sel_found && !reset_i;
  assign issue_fire      = issue_valid_o && issue_ready_i && !flush_i;
  assign issue_payload_o = payload_q[sel_idx];
  assign issue_prs1_o    = prs1_q[sel_idx];
  assign issue_prs2_o    = prs2_q[sel_idx];
  assign issue_prd_o     = prd_q[sel_idx];
  assign count_o         = reset_i ? '0 : count_q;

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    for (int i = 0; i < DEPTH; i++) begin
      prs1_d[i]    = prs1_q[i];
      prs2_d[i]    = prs2_q[i];
      prd_d[i]     = prd_q[i];
      payload_d[i] = payload_q[i];
      if (cdb_en_i && valid_q[i] && (prs1_q[i] == cdb_tag_i)) rdy1_d[i] = 1'b1;
      if (cdb_en_i && valid_q[i] && (prs2_q[i] == cdb_tag_i)) rdy2_d[i] = 1'b1;
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    // The allocated slot was free, so it never collides with the issuing slot.
    if (alloc_fire) begin
      valid_d[free_idx]   = 1'b1;
      prs1_d[free_idx]    = alloc_prs1_i;
      prs2_d[free_idx]    = alloc_prs2_i;
      prd_d[free_idx]     = alloc_prd_i;
      payload_d[free_idx] = alloc_payload_i;
      rdy1_d[free_idx]    = alloc_prs1_rdy_i || (alloc_prs1_i == '0) ||
                            (cdb_en_i && (cdb_tag_i == alloc_prs1_i));
      rdy2_d[free_idx]    = alloc_prs2_rdy_i || (alloc_prs2_i == '0) ||
                            (cdb_en_i && (cdb_tag_i == alloc_prs2_i));
    end
    count_d = count_q + CW'(alloc_fire) - CW'(issue_fire);
    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
    end
  end

`ifdef RS_AGE_SELECT_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
      if (alloc_fire) older_d[i][free_idx] = 1'b0;
      if (flush_i) older_d[i] = '0;
    end
    if (alloc_fire && !flush_i) older_d[free_idx] = valid_q;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset_i) older_q[i] <= '0;
      else         older_q[i] <= older_d[i];
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rdy1_q <= rdy1_d;
    rdy2_q <= rdy2_d;
    for (int i = 0; i < DEPTH; i++) begin
      prs1_q[i]    <= prs1_d[i];
      prs2_q[i]    <= prs2_d[i];
      prd_q[i]     <= prd_d[i];
      payload_q[i] <= payload_d[i];
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed table, hand sequences, and random traffic
// checked against an entry-list model with allocation sequence numbers.
module tb_rs_station;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, fl, av, r1, r2, ce, ir;
  logic [4:0]  p1, p2, pd, ct;
  logic [63:0] pl;

  logic        alloc_ready, issue_valid;
  logic [63:0] issue_payload;
  logic [4:0]  issue_prs1, issue_prs2, issue_prd;
  logic [3:0]  count;

  rs_station #(.DEPTH(DEPTH), .TAG_W(5), .PAYLOAD_W(64)) dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .flush_i         (fl),
    .alloc_valid_i   (av),
    .alloc_ready_o   (alloc_ready),
    .alloc_payload_i (pl),
    .alloc_prs1_i    (p1),
    .alloc_prs2_i    (p2),
    .alloc_prd_i     (pd),
    .alloc_prs1_rdy_i(r1),
    .alloc_prs2_rdy_i(r2),
    .cdb_en_i        (ce),
    .cdb_tag_i       (ct),
    .issue_valid_o   (issue_valid),
    .issue_ready_i   (ir),
    .issue_payload_o (issue_payload),
    .issue_prs1_o    (issue_prs1),
    .issue_prs2_o    (issue_prs2),
    .issue_prd_o     (issue_prd),
    .count_o         (count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a slot list where each occupant remembers when it arrived.
  typedef struct {
    bit          v, a, b;
    logic [4:0]  s1, s2, d;
    logic [63:0] p;
    int unsigned seq;
  } ent_t;
  ent_t        m[DEPTH];
  int          m_count = 0;
  int unsigned seq_ctr = 0;

  function automatic int model_sel();
    int idx = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].a && m[i].b) begin
        if (idx < 0) idx = i;
`ifdef RS_AGE_SELECT_EN
        else if (m[i].seq < m[idx].seq) idx = i;
`endif
      end
    end
    return idx;
  endfunction

  task automatic model_check();
    int s = model_sel();
    bit exp_iv = !rst && (s >= 0);
    chk("count", count, rst ? 0 : m_count);
    chk("alloc_ready", alloc_ready, !rst && !fl && (m_count != DEPTH));
    chk("issue_valid", issue_valid, exp_iv);
    if (exp_iv) begin
      chk("issue_prd", issue_prd, m[s].d);
      chk("issue_prs1", issue_prs1, m[s].s1);
      chk("issue_prs2", issue_prs2, m[s].s2);
      chk("issue_payload", issue_payload, m[s].p);
    end
  endtask

  task automatic model_step();
    int s, f;
    bit afire, ifire;
    if (rst || fl) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 0;
      m_count = 0;
      return;
    end
    s = model_sel();
    afire = av && (m_count != DEPTH);
    ifire = (s >= 0) && ir;
    f = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].v) f = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && ce && m[i].s1 == ct) m[i].a = 1;
      if (m[i].v && ce && m[i].s2 == ct) m[i].b = 1;
    end
    if (ifire) m[s].v = 0;
    if (afire) begin
      m[f].v   = 1;
      m[f].s1  = p1;
      m[f].s2  = p2;
      m[f].d   = pd;
      m[f].p   = pl;
      m[f].a   = r1 || (p1 == 0) || (ce && ct == p1);
      m[f].b   = r2 || (p2 == 0) || (ce && ct == p2);
      m[f].seq = seq_ctr++;
    end
    m_count += int'(afire) - int'(ifire);
  endtask

  // Inputs are driven at the falling edge; one call covers one clock cycle.
  task automatic tick();
    #1 model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    av = 0; r1 = 0; r2 = 0; ce = 0; ir = 0; fl = 0; rst = 0;
    p1 = 0; p2 = 0; pd = 0; ct = 0; pl = 0;
  endtask

  task automatic set_alloc(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                           input logic ra, input logic rb);
    av = 1; p1 = a1; p2 = a2; pd = d; r1 = ra; r2 = rb; pl = {32'hC0DE0000, 27'h0, d};
  endtask

  typedef struct {
    logic       av, r1, r2, ce, ir;
    logic [4:0] p1, p2, pd, ct;
    int         e_cnt;
    logic       e_ar, e_iv;
    logic [4:0] e_prd;
  } vec_t;
  vec_t tbl[10];

  initial begin
    //          av r1 r2 ce ir  p1 p2 pd ct  cnt ar iv prd
    tbl[0] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0,  2, 3, 4, 0,  0, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 1, 0,  0, 0, 0, 2,  1, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 0,  0, 0, 0, 3,  1, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 4};
    tbl[5] = '{0, 0, 0, 0, 1,  0, 0, 0, 0,  1, 1, 1, 4};
    tbl[6] = '{1, 0, 0, 1, 0,  5, 0, 6, 5,  0, 1, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 6};
    tbl[8] = '{0, 0, 0, 0, 1,  0, 0, 0, 0,  1, 1, 1, 6};
    tbl[9] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0};

    set_idle();
    rst = 1;
    for (int i = 0; i < DEPTH; i++) m[i].v = 0;
    @(negedge clk);
    tick();
    #1 chk("ready_in_reset", alloc_ready, 0);
    tick();
    rst = 0;
    #1 chk("ready_after_reset", alloc_ready, 1);
    chk("count_after_reset", count, 0);
    chk("ivalid_after_reset", issue_valid, 0);

    for (int k = 0; k < 10; k++) begin
      set_idle();
      av = tbl[k].av; r1 = tbl[k].r1; r2 = tbl[k].r2; ce = tbl[k].ce; ir = tbl[k].ir;
      p1 = tbl[k].p1; p2 = tbl[k].p2; pd = tbl[k].pd; ct = tbl[k].ct;
      pl = {59'h0, tbl[k].pd};
      #1;
      chk($sformatf("tbl%0d_count", k), count, tbl[k].e_cnt);
      chk($sformatf("tbl%0d_ready", k), alloc_ready, tbl[k].e_ar);
      chk($sformatf("tbl%0d_ivalid", k), issue_valid, tbl[k].e_iv);
      if (tbl[k].e_iv) chk($sformatf("tbl%0d_prd", k), issue_prd, tbl[k].e_prd);
      tick();
    end

    // Fill to capacity with ready work while the FU stalls.
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      set_alloc(1, 1, 5'(8 + i), 1, 1);
      tick();
    end
    set_idle();
    #1 chk("full_count", count, 8);
    chk("full_ready", alloc_ready, 0);
    set_alloc(1, 1, 30, 1, 1);
    ir = 1;
    #1 chk("full_ready_while_issuing", alloc_ready, 0);
    chk("full_issue_prd", issue_prd, 8);
    tick();
    set_idle();
    #1 chk("after_one_issue_count", count, 7);
    chk("after_one_issue_ready", alloc_ready, 1);
    ir = 1;
    for (int i = 0; i < 10; i++) tick();
    set_idle();
    #1 chk("drained_count", count, 0);

    // Older blocked entry vs. a younger ready one reusing a lower-freed slot.
    set_alloc(7, 0, 20, 0, 0); tick();
    set_idle(); set_alloc(1, 2, 21, 1, 1); tick();
    set_idle(); ir = 1;
    #1 chk("order_b_prd", issue_prd, 21);
    tick();
    set_idle(); set_alloc(3, 4, 22, 1, 1); tick();
    set_idle(); ce = 1; ct = 7; tick();
    set_idle(); ir = 1;
    #1 chk("order_first_prd", issue_prd, 20);
    tick();
    #1 chk("order_second_prd", issue_prd, 22);
    tick();
    set_idle();
    #1 chk("order_empty", count, 0);

    // Flush beats a same-cycle allocate.
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_alloc(9, 10, 5'(11 + i), 0, 0); tick();
    end
    set_idle();
    #1 chk("pre_flush_count", count, 3);
    set_alloc(1, 1, 15, 1, 1);
    fl = 1;
    #1 chk("flush_ready", alloc_ready, 0);
    tick();
    set_idle();
    #1 chk("flush_count", count, 0);
    chk("flush_ivalid", issue_valid, 0);
    tick();
    #1 chk("flush_nothing_alloc", count, 0);

    // Random traffic with a small tag space so broadcasts hit often.
    for (int c = 0; c < 3000; c++) begin
      av  = ($urandom_range(0, 3) != 0);
      p1  = 5'($urandom_range(0, 7));
      p2  = 5'($urandom_range(0, 7));
      pd  = 5'($urandom_range(0, 31));
      r1  = ($urandom_range(0, 3) == 0);
      r2  = ($urandom_range(0, 3) == 0);
      ce  = ($urandom_range(0, 1) == 1);
      ct  = 5'($urandom_range(0, 7));
      ir  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 299) == 0);
      pl  = {$urandom, $urandom};
      tick();
    end
    set_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Parametrised reservation station for one functional-unit class (ALU, MUL or LSU); one instance per class.
- Sits between rename/dispatch and the FU. Buffers up to DEPTH renamed instructions.
- Tracks source-operand readiness through CDB tag broadcasts and issues one ready instruction per cycle to the FU over a valid/ready handshake.
- Adds configurable depth, tag width and payload width, an allocate handshake, a flush, an occupancy count, and age-ordered select.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..32.
- TAG_W, 5, physical register tag width.
- PAYLOAD_W, 64, opaque payload width ({pc, inst}), stored and forwarded unchanged.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous squash of all entries.
- alloc_valid_i  in  1  dispatch presents an instruction.
- alloc_ready_o  out  1  a free entry exists; allocation fires when valid && ready.
- alloc_payload_i  in  PAYLOAD_W  pc/inst payload.
- alloc_prs1_i  in  TAG_W  source 1 tag.
- alloc_prs2_i  in  TAG_W  source 2 tag.
- alloc_prd_i  in  TAG_W  destination tag.
- alloc_prs1_rdy_i  in  1  source 1 already available.
- alloc_prs2_rdy_i  in  1  source 2 already available.
- cdb_en_i  in  1  CDB broadcast valid.
- cdb_tag_i  in  TAG_W  broadcast destination tag.
- issue_valid_o  out  1  a selected entry has both sources ready.
- issue_ready_i  in  1  FU accepts; issue fires when valid && ready.
- issue_payload_o  out  PAYLOAD_W  payload of the selected entry.
- issue_prs1_o  out  TAG_W  source 1 tag of the selected entry.
- issue_prs2_o  out  TAG_W  source 2 tag of the selected entry.
- issue_prd_o  out  TAG_W  destination tag of the selected entry.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Per-entry state: valid, rdy1, rdy2, tags, payload.
- Reset or flush (next edge): all valid bits cleared, count_o=0, age state cleared.
- Outputs during and after reset: issue_valid_o=0, issue tag/payload outputs are don't-care while issue_valid_o=0, count_o=0. alloc_ready_o is 0 while reset_i=1 and 1 once reset is released.
- Flush and reset take priority over same-cycle allocate and issue: neither fires, no entry is written.
- alloc_ready_o = (count_o != DEPTH) && !reset_i && !flush_i. It depends only on registered state, so there is no same-cycle reuse of the entry being issued. When full, alloc_ready_o=0 even if an issue fires that cycle.
- Allocation writes the lowest-index free entry at the edge.
- rdy bit on allocate = rdy_i || (src tag == 0) || (cdb_en_i && cdb_tag_i == src tag). The same-cycle CDB match must not be lost.
- Wakeup: each valid entry sets rdy1/rdy2 at the edge when cdb_en_i=1 and the tag matches. A single broadcast may wake multiple entries and both sources of one entry.
- Eligible entry: valid && rdy1 && rdy2.
- issue_valid_o and issue_* outputs are combinational from registered state (no CDB-to-issue bypass). Minimum latency:
  - allocation to issue: 1 cycle;
  - CDB to issue: 1 cycle.
- Issue fire: the selected entry's valid bit clears at the edge.
- Issue outputs must stay stable while issue_valid_o=1 && issue_ready_i=0, unless a higher-priority entry becomes eligible. Consumers must not rely on stability across cycles.
- count_o next = count + alloc_fire - issue_fire; simultaneous allocate and issue leaves the count unchanged.
- Select policy is set by the optional feature below.
- No counter wraps. Allocation while full and issue while empty are impossible by construction.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- Defined: a DEPTH x DEPTH age matrix records allocation order. On allocate, the new entry is marked younger than all currently valid entries. Select picks the oldest eligible entry.
- Undefined: no age state; select picks the lowest-index eligible entry.
- Allocate, wakeup, count and handshake behaviour are identical in both builds.

Test Plan:
- Reset, then idle -> count_o=0, issue_valid_o=0, alloc_ready_o=1 after reset_i drops.
- Allocate prs1=2, prs2=3, both rdy=0, prd=4 -> held with issue_valid_o=0. cdb tag 2 -> still 0. cdb tag 3 -> next cycle issue_valid_o=1, issue_prd_o=4. issue_ready_i=1 -> count_o back to 0.
- Allocate with prs1=5 while cdb_en_i=1, cdb_tag_i=5, and prs2 tag 0 -> entry is eligible the next cycle.
- Fill DEPTH=8 with ready instructions while issue_ready_i=0 -> count_o=8, alloc_ready_o=0. Assert issue_ready_i for one cycle -> count_o=7, alloc_ready_o=1.
- Allocate A (waiting on tag 7) in entry 0, then B (ready) in entry 1. Issue B, allocate C (ready) into entry 1, then wake A with tag 7 -> with RS_AGE_SELECT_EN issue order is A then C; without it, entry 0 (A) issues first by index.
- Assert flush_i with 3 entries valid plus alloc_valid_i=1 -> next cycle count_o=0, issue_valid_o=0, nothing allocated.
